// File: rtl/mem_rw_sequencer.sv
// mem_rw_sequencer: round-robin write-then-readback sequencer sharing one memory port
// Define SEQ_ASSERT_EN to compile in the wr->rd protocol assertions.
module mem_rw_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int GAP    = 2,
   parameter int RD_LEN = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          gnt,
   output logic [1:0]          done,
   output logic                err,
   output logic [DATA_W-1:0]   rdata,
   output logic                wr,
   output logic                rd,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);
   localparam int CMAX = GAP > RD_LEN ? GAP : RD_LEN;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] GEND = CW'(GAP > 1 ? GAP - 2 : 0);
   localparam logic [CW-1:0] REND = CW'(RD_LEN - 1);
   typedef enum logic [2:0] {IDLE, WRITE, GAPW, READ, DONE} state_t;
   state_t            state;
   logic [CW-1:0]     cnt;
   logic              sel, ptr, mis, win, miss;
   logic [ADDR_W-1:0] addr_w;
   logic [DATA_W-1:0] data_w;
   // the RR pointer only matters when both requesters compete
   assign win    = &req ? ptr : req[1];
   assign addr_w = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
   assign data_w = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
   assign miss   = mem_rdata != mem_wdata;
   // sequencer FSM; gnt and wr rise together on the edge entering WRITE
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sel       <= 1'b0;
         ptr       <= 1'b0;
         mis       <= 1'b0;
         gnt       <= '0;
         done      <= '0;
         err       <= 1'b0;
         rdata     <= '0;
         wr        <= 1'b0;
         rd        <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         gnt  <= '0;
         done <= '0;
         case (state)
            IDLE: if (|req) begin
               gnt       <= win ? 2'b10 : 2'b01;
               sel       <= win;
               mem_addr  <= addr_w;
               mem_wdata <= data_w;
               wr        <= 1'b1;
               mis       <= 1'b0;
               state     <= WRITE;
            end
            WRITE: begin
               wr    <= 1'b0;
               cnt   <= '0;
               rd    <= GAP == 1;
               state <= GAP == 1 ? READ : GAPW;
            end
            GAPW: if (cnt == GEND) begin
               cnt   <= '0;
               rd    <= 1'b1;
               state <= READ;
            end else cnt <= cnt + CW'(1);
            READ: begin
               mis <= mis | miss;
               if (cnt == REND) begin
                  rd    <= 1'b0;
                  done  <= sel ? 2'b10 : 2'b01;
                  err   <= mis | miss;
                  rdata <= mem_rdata;
                  ptr   <= ~sel;
                  state <= DONE;
               end else cnt <= cnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef SEQ_ASSERT_EN
   // protocol checks on the memory-side strobes and the one-hot pulses
   a_wr_rd: assert property (@(posedge clk) disable iff (rst) $rose(wr) |-> ##GAP rd [*RD_LEN])
      $info("a_wr_rd pass %0t", $time); else $error("a_wr_rd violated %0t", $time);
   a_rd_len: assert property (@(posedge clk) disable iff (rst) $rose(rd) |-> rd [*RD_LEN] ##1 !rd)
      $info("a_rd_len pass %0t", $time); else $error("a_rd_len violated %0t", $time);
   a_gnt: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
      $info("a_gnt pass %0t", $time); else $error("a_gnt violated %0t", $time);
   a_done: assert property (@(posedge clk) disable iff (rst) $onehot0(done))
      $info("a_done pass %0t", $time); else $error("a_done violated %0t", $time);
   a_excl: assert property (@(posedge clk) disable iff (rst) !(wr && rd))
      $info("a_excl pass %0t", $time); else $error("a_excl violated %0t", $time);
`endif
endmodule

// File: tb/tb_mem_rw_sequencer.sv
// tb_mem_rw_sequencer: table vectors with a done scoreboard, plus contention, reset and GAP=1 sequences
module tb_mem_rw_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   logic [1:0]  req, req1, gnt, gnt1, done, done1;
   logic [15:0] req_addr, req_wdata;
   logic        err, err1, wr, wr1, rd, rd1;
   logic [7:0]  rdata, rdata1, mem_addr, ma1, mem_wdata, mw1, mem_rdata, mr1;
   mem_rw_sequencer u0 (.clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .done(done), .err(err), .rdata(rdata), .wr(wr), .rd(rd), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
   mem_rw_sequencer #(.GAP(1), .RD_LEN(3)) u1 (.clk(clk), .rst(rst), .req(req1), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt1), .done(done1), .err(err1), .rdata(rdata1), .wr(wr1), .rd(rd1),
      .mem_addr(ma1), .mem_wdata(mw1), .mem_rdata(mr1));
   int checks = 0, failures = 0;
   task automatic chk(string n, int got, int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", n, got, exp);
      end
   endtask
   task automatic tmo(string n);
      checks++;
      failures++;
      $display("FAIL %s: bound expired, got no event, required one", n);
   endtask
   // memory model with optional corruption of one readback cycle
   logic [7:0] mem [256];
   int         rdn = 0, bad_idx = -1;
   logic [7:0] bad_val = 8'h00;
   always @(posedge clk) begin
      if (wr) mem[mem_addr] <= mem_wdata;
      rdn <= rd ? rdn + 1 : 0;
   end
   assign mem_rdata = (rdn == bad_idx) ? bad_val : mem[mem_addr];
   assign mr1 = mw1;
   typedef struct {logic [1:0] done; logic err; logic [7:0] rdata;} exp_t;
   exp_t       sb[$];
   logic [1:0] glog[$];
   // protocol monitor and scoreboard consumer, sampling just after each edge
   int         cyc = 0, twr = 0, rdlen = 0;
   logic       prev_rd = 1'b0, havewr = 1'b0;
   logic [7:0] waddr, wdat;
   exp_t       em;
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         havewr = 1'b0;
         prev_rd = 1'b0;
         rdlen = 0;
      end else begin
         if (wr) begin
            chk("wr_rd_overlap", int'(rd), 0);
            if (havewr) chk("wr_spacing", int'((cyc - twr) >= 6), 1);
            twr = cyc;
            havewr = 1'b1;
            waddr = mem_addr;
            wdat = mem_wdata;
         end
         if (rd && !prev_rd) chk("rd_rise_gap", cyc - twr, 2);
         if (rd) rdlen++;
         if (!rd && prev_rd) begin
            chk("rd_len", rdlen, 2);
            chk("done_after_rd", int'(|done), 1);
            rdlen = 0;
         end
         if (gnt != 2'b00) glog.push_back(gnt);
         if (done != 2'b00) begin
            if (sb.size() == 0) tmo("unexpected_done");
            else begin
               em = sb.pop_front();
               chk("sb_done", done, em.done);
               chk("sb_err", err, em.err);
               chk("sb_rdata", rdata, em.rdata);
               chk("addr_stable", mem_addr, waddr);
               chk("wdata_stable", mem_wdata, wdat);
            end
         end
         prev_rd = rd;
      end
   end
   typedef struct {
      logic [1:0] req;
      logic [7:0] a0, d0, a1, d1;
      int         bidx;
      logic [7:0] bval;
      logic [1:0] eg;
      logic       eerr;
      logic [7:0] erd;
   } vec_t;
   vec_t vt[8];
   vec_t v;
   int   n;
   initial begin
      vt[0] = '{2'b01, 8'h10, 8'hA5, 8'h00, 8'h00, -1, 8'h00, 2'b01, 1'b0, 8'hA5};
      vt[1] = '{2'b01, 8'h10, 8'hA5, 8'h00, 8'h00,  1, 8'h5A, 2'b01, 1'b1, 8'h5A};
      vt[2] = '{2'b10, 8'h00, 8'h00, 8'h20, 8'h3C, -1, 8'h00, 2'b10, 1'b0, 8'h3C};
      vt[3] = '{2'b11, 8'h30, 8'h11, 8'h31, 8'h22, -1, 8'h00, 2'b01, 1'b0, 8'h11};
      vt[4] = '{2'b11, 8'h40, 8'h77, 8'h41, 8'h88, -1, 8'h00, 2'b10, 1'b0, 8'h88};
      vt[5] = '{2'b10, 8'h00, 8'h00, 8'h50, 8'hC3,  0, 8'hFF, 2'b10, 1'b1, 8'hC3};
      vt[6] = '{2'b01, 8'h60, 8'h00, 8'h00, 8'h00,  1, 8'hFF, 2'b01, 1'b1, 8'hFF};
      vt[7] = '{2'b01, 8'h61, 8'hFF, 8'h00, 8'h00, -1, 8'h00, 2'b01, 1'b0, 8'hFF};
      rst = 1'b1; req = 2'b00; req1 = 2'b00; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({gnt, done, err, rdata, wr, rd, mem_addr, mem_wdata}), 0);
      chk("reset_outputs_g1", int'({gnt1, done1, err1, rdata1, wr1, rd1, ma1, mw1}), 0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         v = vt[i];
         req_addr = {v.a1, v.a0};
         req_wdata = {v.d1, v.d0};
         bad_idx = v.bidx;
         bad_val = v.bval;
         sb.push_back('{v.eg, v.eerr, v.erd});
         req = v.req;
         n = 0;
         while (gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
         if (gnt == 2'b00) tmo("vec_gnt");
         else begin
            chk("vec_gnt", gnt, v.eg);
            chk("vec_addr", mem_addr, v.eg[1] ? v.a1 : v.a0);
            chk("vec_wdata", mem_wdata, v.eg[1] ? v.d1 : v.d0);
         end
         req = 2'b00;
         n = 0;
         while (sb.size() != 0 && n < 30) begin @(negedge clk); n++; end
         if (sb.size() != 0) begin tmo("vec_done"); sb.delete(); end
         repeat (2) @(negedge clk);
         chk("vec_err_hold", err, v.eerr);
         chk("vec_rdata_hold", rdata, v.erd);
      end
      bad_idx = -1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      req_addr = {8'h71, 8'h70};
      req_wdata = {8'h62, 8'h61};
      glog.delete();
      for (int k = 0; k < 4; k++) sb.push_back('{k % 2 ? 2'b10 : 2'b01, 1'b0, k % 2 ? 8'h62 : 8'h61});
      req = 2'b11;
      n = 0;
      while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
      req = 2'b00;
      if (sb.size() != 0) begin tmo("rr_done"); sb.delete(); end
      repeat (10) @(negedge clk);
      chk("rr_count", glog.size(), 4);
      for (int k = 0; k < glog.size() && k < 4; k++) chk("rr_order", glog[k], k % 2 ? 2 : 1);
      req_addr = {8'h91, 8'h90};
      req_wdata = {8'hB2, 8'hB1};
      req = 2'b01;
      n = 0;
      while (!rd && n < 20) begin @(negedge clk); n++; end
      req = 2'b00;
      if (!rd) tmo("mid_rd");
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rd", rd, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_wr", wr, 0);
      chk("mid_rst_rdata", rdata, 0);
      rst = 1'b0;
      @(negedge clk);
      sb.push_back('{2'b10, 1'b0, 8'hB2});
      req = 2'b10;
      n = 0;
      while (gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
      if (gnt == 2'b00) tmo("post_rst_gnt"); else chk("post_rst_gnt", gnt, 2'b10);
      req = 2'b00;
      n = 0;
      while (sb.size() != 0 && n < 30) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin tmo("post_rst_done"); sb.delete(); end
      req_addr = {8'h00, 8'hA0};
      req_wdata = {8'h00, 8'h5C};
      req1 = 2'b01;
      n = 0;
      while (gnt1 == 2'b00 && n < 20) begin @(negedge clk); n++; end
      req1 = 2'b00;
      if (gnt1 == 2'b00) tmo("g1_gnt");
      else begin
         chk("g1_gnt", gnt1, 2'b01);
         chk("g1_wr", wr1, 1);
         @(negedge clk);
         chk("g1_wr_pulse", wr1, 0);
         chk("g1_rd_rise", rd1, 1);
         n = 0;
         while (rd1 && n < 10) begin n++; @(negedge clk); end
         chk("g1_rd_len", n, 3);
         chk("g1_done", done1, 2'b01);
         chk("g1_err", err1, 0);
         chk("g1_rdata", rdata1, 8'h5C);
      end
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
